// File: rtl/hyperbus_trans_splitter.sv
// Splits an upstream HyperBus request (start word address + length) into
// PHY transactions that never cross a MAX_BURST-aligned word boundary.
// This keeps each chip-select assertion within the device tCSM limit.
module hyperbus_trans_splitter #(
    parameter int BURST_WIDTH = 12,
    parameter int NR_CS       = 2,
    parameter int MAX_BURST   = 64
) (
    input  logic                   clk270,
    input  logic                   rst_ni,
    // upstream request
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_address_i,
    input  logic [NR_CS-1:0]       req_cs_i,
    input  logic                   req_write_i,
    input  logic [BURST_WIDTH-1:0] req_len_i,
    // PHY transaction
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    // status
    output logic                   done_o,
    output logic                   busy_o
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q;
    logic [NR_CS-1:0]       cs_q;
    logic                   write_q;
    logic [BURST_WIDTH-1:0] rem_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic                   done_q;

    logic                   req_hs, trans_hs, last_chunk;
    logic [31:0]            addr_nxt;
    logic [BURST_WIDTH-1:0] rem_nxt;

    // Words until the next MAX_BURST boundary, clipped to what is left.
    // MAX_BURST <= 2^(BURST_WIDTH-1), so the space value always fits.
    function automatic logic [BURST_WIDTH-1:0] chunk_of(input logic [31:0] a,
                                                        input logic [BURST_WIDTH-1:0] rem);
        logic [31:0] space;
        space = 32'(MAX_BURST) - (a & (32'(MAX_BURST) - 32'd1));
        if (32'(rem) < space) return rem;
        else                  return space[BURST_WIDTH-1:0];
    endfunction

    assign req_hs     = req_valid_i && (state_q == IDLE);
    assign trans_hs   = trans_ready_i && (state_q == ISSUE);
    assign last_chunk = (rem_q == burst_q);
    assign addr_nxt   = addr_q + 32'(burst_q);   // wraps modulo 2^32
    assign rem_nxt    = rem_q - burst_q;

    // State register.
    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and handshake outputs; valid is a pure state decode.
    always_comb begin
        state_d       = state_q;
        req_ready_o   = 1'b0;
        trans_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && (req_len_i != '0)) state_d = ISSUE;
            end
            ISSUE: begin
                trans_valid_o = 1'b1;
                if (trans_ready_i && last_chunk) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request registers: load on accept, advance by one chunk per PHY handshake.
    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            cs_q    <= '0;
            write_q <= 1'b0;
            rem_q   <= '0;
            burst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (req_hs) begin
                if (req_len_i == '0) begin
                    // empty request: acknowledge without touching the PHY
                    done_q <= 1'b1;
                end else begin
                    addr_q  <= req_address_i;
                    cs_q    <= req_cs_i;
                    write_q <= req_write_i;
                    rem_q   <= req_len_i;
                    burst_q <= chunk_of(req_address_i, req_len_i);
                end
            end else if (trans_hs) begin
                addr_q  <= addr_nxt;
                rem_q   <= rem_nxt;
                burst_q <= chunk_of(addr_nxt, rem_nxt);
                if (last_chunk) done_q <= 1'b1;
            end
        end
    end

    assign trans_address_o = addr_q;
    assign trans_cs_o      = cs_q;
    assign trans_write_o   = write_q;
    assign trans_burst_o   = burst_q;
    assign done_o          = done_q;
    assign busy_o          = (state_q != IDLE);

endmodule
